// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial parity framer.
package serial_pkg;

   typedef enum logic {
      DATA   = 1'b0,
      PARITY = 1'b1
   } state_t;

   localparam logic EVEN = 1'b0;
   localparam logic ODD  = 1'b1;

   // Bit-counter width needed to index DATA_W data bits.
   function automatic int cnt_width(input int data_w);
      return (data_w < 2) ? 1 : $clog2(data_w);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up on inc and stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/serial_parity_framer.sv
// Serial bit-stream framer: DATA_W data bits (LSB first) then one parity bit.
//
// state  | meaning
// -------+-----------------------------------------------
// DATA   | collecting data bits into the shift register
// PARITY | all data bits in, waiting for the parity bit
module serial_parity_framer
   import serial_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 in_valid,
   input  logic                 in,
   input  logic                 odd_mode,
   output logic                 s,
   output logic                 frame_done,
   output logic                 par_err,
   output logic [DATA_W-1:0]    data_out,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int               CNT_W = cnt_width(DATA_W);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

   state_t            state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shift;
   logic              mode_q;
   logic              err_bit;
   logic              err_inc;

   // Parity check result for the bit currently presented in PARITY.
   assign err_bit = s ^ in ^ mode_q;
   assign err_inc = in_valid && !clr && (state == PARITY) && err_bit;

   // Framing FSM, deserialiser and running parity; clr aborts the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= DATA;
         bit_cnt    <= '0;
         s          <= 1'b0;
         frame_done <= 1'b0;
         par_err    <= 1'b0;
         data_out   <= '0;
         shift      <= '0;
         mode_q     <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         par_err    <= 1'b0;
         if (clr) begin
            state   <= DATA;
            bit_cnt <= '0;
            s       <= 1'b0;
         end else if (in_valid) begin
            case (state)
               DATA: begin
                  shift[bit_cnt] <= in;
                  s              <= s ^ in;
                  if (bit_cnt == '0) begin
                     mode_q <= odd_mode;
                  end
                  if (bit_cnt == LAST) begin
                     state <= PARITY;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
               PARITY: begin
                  frame_done <= 1'b1;
                  par_err    <= err_bit;
                  data_out   <= shift;
                  state      <= DATA;
                  s          <= 1'b0;
                  bit_cnt    <= '0;
               end
               default: begin
                  state <= DATA;
               end
            endcase
         end
      end
   end

   sat_counter #(
      .W(ERR_CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (err_inc),
      .count (err_count)
   );

endmodule

// File: tb/tb_serial_parity_framer.sv
// Self-checking bench for serial_parity_framer (scoreboard of expected frames).
module tb_serial_parity_framer;

   localparam int DATA_W = 8;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              perr;
      logic [7:0]        cnt8;
      logic [1:0]        cnt2;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clr = 1'b0;
   logic              in_valid = 1'b0;
   logic              bit_in = 1'b0;
   logic              odd_mode = 1'b0;

   logic              s, frame_done, par_err;
   logic [DATA_W-1:0] data_out;
   logic [7:0]        err_count;
   logic              s2, frame_done2, par_err2;
   logic [DATA_W-1:0] data_out2;
   logic [1:0]        err_count2;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   fd_cnt   = 0;
   logic [7:0] m_cnt8 = '0;
   logic [1:0] m_cnt2 = '0;
   logic       m_s    = 1'b0;

   always #5 clk = ~clk;

   serial_parity_framer #(.DATA_W(DATA_W), .ERR_CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in(bit_in),
      .odd_mode(odd_mode), .s(s), .frame_done(frame_done), .par_err(par_err),
      .data_out(data_out), .err_count(err_count)
   );

   serial_parity_framer #(.DATA_W(DATA_W), .ERR_CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in(bit_in),
      .odd_mode(odd_mode), .s(s2), .frame_done(frame_done2), .par_err(par_err2),
      .data_out(data_out2), .err_count(err_count2)
   );

   // Scoreboard consumer: every frame_done pops and checks one expected frame.
   always @(negedge clk) begin
      if (rst_n) begin
         n_assert++;
         if (par_err && !frame_done) begin
            n_fail++;
            $display("FAIL par_err_without_done: par_err=%b frame_done=%b", par_err, frame_done);
         end
         n_assert++;
         if (frame_done2 !== frame_done) begin
            n_fail++;
            $display("FAIL sat_done_align: got %b want %b", frame_done2, frame_done);
         end
         if (frame_done) begin
            fd_cnt++;
            n_assert++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_frame_done: data_out=%h queue empty", data_out);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (data_out !== e.data) begin
                  n_fail++;
                  $display("FAIL data_out: got %h want %h", data_out, e.data);
               end
               n_assert++;
               if (par_err !== e.perr) begin
                  n_fail++;
                  $display("FAIL par_err: got %b want %b", par_err, e.perr);
               end
               n_assert++;
               if (err_count !== e.cnt8) begin
                  n_fail++;
                  $display("FAIL err_count: got %0d want %0d", err_count, e.cnt8);
               end
               n_assert++;
               if (err_count2 !== e.cnt2) begin
                  n_fail++;
                  $display("FAIL err_count_sat: got %0d want %0d", err_count2, e.cnt2);
               end
            end
         end
      end
   end

   task automatic drive(input logic v, input logic b, input logic c);
      in_valid = v;
      bit_in   = b;
      clr      = c;
      @(posedge clk);
      #1;
      if (c) begin
         m_cnt8 = '0;
         m_cnt2 = '0;
         m_s    = 1'b0;
      end
      clr      = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic check_s(input string tag);
      n_assert++;
      if (s !== m_s) begin
         n_fail++;
         $display("FAIL s_%s: got %b want %b", tag, s, m_s);
      end
   endtask

   // Data bits with optional stall cycles; optionally flips odd_mode mid-frame.
   task automatic send_data(input logic [DATA_W-1:0] d, input logic odd,
                            input bit gaps, input bit flip, output logic mode_used);
      odd_mode  = odd;
      mode_used = odd;
      for (int i = 0; i < DATA_W; i++) begin
         if (flip && i == DATA_W / 2) odd_mode = ~odd_mode;
         drive(1'b1, d[i], 1'b0);
         m_s = m_s ^ d[i];
         check_s("data");
         if (gaps) begin
            drive(1'b0, 1'b0, 1'b0);
            check_s("stall");
         end
      end
   endtask

   task automatic send_parity(input logic [DATA_W-1:0] d, input logic p, input logic mode_used);
      exp_t e;
      e.perr = (^d) ^ p ^ mode_used;
      if (e.perr) begin
         if (m_cnt8 != 8'hFF) m_cnt8 = m_cnt8 + 8'd1;
         if (m_cnt2 != 2'd3)  m_cnt2 = m_cnt2 + 2'd1;
      end
      e.data = d;
      e.cnt8 = m_cnt8;
      e.cnt2 = m_cnt2;
      sb.push_back(e);
      drive(1'b1, p, 1'b0);
      m_s = 1'b0;
      check_s("after_parity");
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic odd,
                             input bit gaps, input bit flip);
      logic m;
      send_data(d, odd, gaps, flip, m);
      send_parity(d, p, m);
   endtask

   task automatic check_idle_outputs(input string tag);
      n_assert++;
      if ({s, frame_done, par_err, data_out, err_count, s2, frame_done2, par_err2, data_out2, err_count2} !== '0) begin
         n_fail++;
         $display("FAIL %s: s=%b fd=%b pe=%b data=%h cnt=%0d sat_cnt=%0d want all zero",
                  tag, s, frame_done, par_err, data_out, err_count, err_count2);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset_values");
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_even();
      int f0;
      logic [7:0] exp_s;
      logic m;
      f0 = fd_cnt;
      exp_s = 8'b0110_0011; // running XOR of 1,0,1,0,0,1,0,1 read as bit i
      odd_mode = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 8'hA5 >> i, 1'b0);
         m_s = exp_s[i];
         check_s("even_const");
      end
      m = 1'b0;
      send_parity(8'hA5, 1'b0, m);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      n_assert++;
      if (fd_cnt != f0 + 1) begin
         n_fail++;
         $display("FAIL even_done_count: got %0d want %0d", fd_cnt - f0, 1);
      end
   endtask

   task automatic test_parity_error();
      send_frame(8'hA5, 1'b1, 1'b0, 0, 0);
      drive(1'b0, 1'b0, 1'b0);
      n_assert++;
      if (err_count !== 8'd1) begin
         n_fail++;
         $display("FAIL perr_count: got %0d want 1", err_count);
      end
   endtask

   task automatic test_mode_stall();
      int f0;
      f0 = fd_cnt;
      send_frame(8'h01, 1'b0, 1'b1, 1, 1);
      repeat (3) drive(1'b0, 1'b0, 1'b0);
      n_assert++;
      if (fd_cnt != f0 + 1) begin
         n_fail++;
         $display("FAIL mode_done_count: got %0d want 1", fd_cnt - f0);
      end
   endtask

   task automatic test_clear();
      int   f0;
      logic m;
      f0 = fd_cnt;
      odd_mode = 1'b0;
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      n_assert++;
      if (err_count !== 8'd0 || s !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_mid: cnt=%0d s=%b want 0 0", err_count, s);
      end
      // clr on the parity bit aborts the frame without a frame_done.
      send_data(8'h5A, 1'b0, 0, 0, m);
      drive(1'b1, 1'b1, 1'b1);
      repeat (2) drive(1'b0, 1'b0, 1'b0);
      n_assert++;
      if (fd_cnt != f0) begin
         n_fail++;
         $display("FAIL clr_abort: got %0d frames want 0", fd_cnt - f0);
      end
      send_frame(8'hFF, 1'b0, 1'b0, 0, 0);
      repeat (2) drive(1'b0, 1'b0, 1'b0);
      n_assert++;
      if (fd_cnt != f0 + 1 || data_out !== 8'hFF) begin
         n_fail++;
         $display("FAIL clr_frame: got %0d frames data %h want 1 ff", fd_cnt - f0, data_out);
      end
   endtask

   task automatic test_back_to_back_saturation();
      int f0;
      drive(1'b0, 1'b0, 1'b1);
      f0 = fd_cnt;
      for (int k = 0; k < 5; k++) send_frame(8'h00, 1'b1, 1'b0, 0, 0);
      repeat (2) drive(1'b0, 1'b0, 1'b0);
      n_assert++;
      if (fd_cnt != f0 + 5 || err_count2 !== 2'd3 || err_count !== 8'd5) begin
         n_fail++;
         $display("FAIL saturation: frames=%0d sat_cnt=%0d cnt=%0d want 5 3 5",
                  fd_cnt - f0, err_count2, err_count);
      end
   endtask

   task automatic test_async_reset();
      logic m;
      send_frame(8'h81, 1'b1, 1'b0, 0, 0);
      odd_mode = 1'b0;
      for (int i = 0; i < 5; i++) drive(1'b1, (i == 0), 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      m_cnt8 = '0;
      m_cnt2 = '0;
      m_s    = 1'b0;
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_data(8'h3C, 1'b0, 0, 0, m);
      send_parity(8'h3C, 1'b0, m);
      repeat (2) drive(1'b0, 1'b0, 1'b0);
      n_assert++;
      if (data_out !== 8'h3C || err_count !== 8'd0) begin
         n_fail++;
         $display("FAIL post_reset_frame: data %h cnt %0d want 3c 0", data_out, err_count);
      end
   endtask

   initial begin
      test_reset();
      test_even();
      test_parity_error();
      test_mode_stall();
      test_clear();
      test_back_to_back_saturation();
      test_async_reset();
      repeat (3) drive(1'b0, 1'b0, 1'b0);
      n_assert++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL missing_frames: %0d expected frames never produced", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_parity_framer.md
Name: serial_parity_framer

Overview:
- Parametrised successor to the single-bit serial parity detector.
- Accepts a serial bit stream with a valid qualifier and groups it into frames of DATA_W data bits followed by one parity bit.
- Tracks running parity with even/odd mode selectable at run time, deserialises each frame, flags parity errors and keeps a saturating error count.
- Sits behind a serial receive front-end and feeds the framed parallel word to downstream logic.

Parameters:
- DATA_W, 8, data bits per frame (legal range 2..32)
- ERR_CNT_W, 8, width of the saturating parity-error counter

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear: abort current frame and zero err_count
- in_valid  input  1  in carries a valid bit this cycle
- in  input  1  serial bit, LSB of data first, parity bit last
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled per frame
- s  output  1  registered running parity (XOR) of data bits accepted so far in the current frame
- frame_done  output  1  one-cycle pulse: a frame completed
- par_err  output  1  one-cycle pulse, coincident with frame_done: parity mismatch
- data_out  output  DATA_W  last completed data word; bit 0 = first bit received
- err_count  output  ERR_CNT_W  number of errored frames, saturating

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=DATA, bit counter=0, s=0, frame_done=0, par_err=0.
  - data_out=0, err_count=0, shift register=0, latched mode=0.
- All outputs are registered. No combinational path from any input to any output.
- States:
  - DATA: collecting data bits.
  - PARITY: waiting for the parity bit.
- Cycles with in_valid=0: no state, counter, s or shift changes. frame_done and par_err return to 0.
- DATA with in_valid=1:
  - Shift in into the shift register at index bit_cnt.
  - s <= s ^ in.
  - If bit_cnt==0, latch odd_mode for this frame. A change to odd_mode mid-frame is ignored.
  - If bit_cnt==DATA_W-1, go to PARITY. Otherwise bit_cnt++.
- PARITY with in_valid=1:
  - err = s ^ in ^ latched_mode.
  - Next cycle: frame_done=1, par_err=err, data_out=shift register.
  - If err=1, err_count increments, saturating at 2^ERR_CNT_W-1 (no wrap).
  - Return to DATA with s=0, bit_cnt=0.
- Latency: frame_done/par_err/data_out update on the cycle after the parity bit is accepted.
- Back-to-back frames: the first data bit of the next frame may be accepted in the cycle immediately after the parity bit, at full rate with no bubble.
- clr=1:
  - Has priority over in_valid. The bit presented that cycle is discarded.
  - Next state: DATA, bit_cnt=0, s=0, err_count=0, frame_done=0, par_err=0.
  - data_out holds its value.
- clr during PARITY with a valid parity bit: the frame is aborted and no frame_done is generated.
- Reset mid-frame: immediate return to reset values. The partial frame is lost.
- data_out is held between frames and only changes on frame completion.

Decomposition:
- Shared package serial_pkg:
  - State enum {DATA, PARITY}.
  - Function/constant for counter width CNT_W = $clog2(DATA_W).
  - Parity-mode constants EVEN=0, ODD=1.
- One natural sub-module: sat_counter (parametrised width, increment enable, synchronous clear, async active-low reset), used for err_count.
- FSM, shift register and running-parity logic stay in the top module.

Test Plan:
- Even mode, DATA_W=8:
  - Stimulus: bits 1,0,1,0,0,1,0,1 (0xA5), then parity 0, in_valid continuous.
  - Response: s toggles to 1,1,0,0,0,1,1,0; one cycle after the parity bit, frame_done=1, par_err=0, data_out=0xA5, err_count=0.
- Same frame with parity 1 -> frame_done=1, par_err=1, err_count=1, data_out=0xA5.
- Mode and stalls:
  - Stimulus: odd_mode=1, frame 0x01 with parity 0, in_valid toggling 1/0 every cycle, odd_mode switched to 0 mid-frame.
  - Response: par_err=0, data_out=0x01; frame_done exactly once.
- Saturation:
  - Stimulus: ERR_CNT_W=2, five consecutive back-to-back errored frames (0x00 with parity 1, even mode).
  - Response: err_count goes 1,2,3,3,3; five frame_done pulses; no idle cycle between frames.
- Clear mid-frame:
  - Stimulus: 3 data bits, then clr=1 with in_valid=1, then frame 0xFF with parity 0 (even).
  - Response: no frame_done until the 0xFF frame; then data_out=0xFF, par_err=0, err_count=0.
- Async reset mid-frame:
  - Stimulus: rst_n low for half a cycle after 5 bits.
  - Response: all outputs are 0 immediately. A subsequent frame 0x3C with parity 0 completes with par_err=0 and data_out=0x3C.
